// File: rtl/regfile_32x32.sv
// ============================================================================
// Module      : regfile_32x32
// Description : 2**AW x DW register file with two combinational read ports,
//               one write port, hard-wired zero at address 0 and a write
//               counter. Optional write-through bypass under the
//               REGFILE_WRITE_BYPASS_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_32x32 #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          Clk,
    input  logic          Clrn,
    input  logic [AW-1:0] Rna,
    input  logic [AW-1:0] Rnb,
    input  logic [AW-1:0] Wn,
    input  logic [DW-1:0] D,
    input  logic          We,
    output logic [DW-1:0] Qa,
    output logic [DW-1:0] Qb,
    output logic [7:0]    Wcnt
);

    localparam int c_depth = 1 << AW;

    logic          w_wr_en;
    logic [DW-1:0] w_regs [0:c_depth-1];
    logic [7:0]    r_wcnt;
    logic [DW-1:0] w_qa;
    logic [DW-1:0] w_qb;

    assign w_wr_en = We && (Wn != '0);

    // Entry 0 has no storage; it is a constant zero in the read mux.
    assign w_regs[0] = '0;

    for (genvar gi = 1; gi < c_depth; gi++) begin : g_reg
        logic [DW-1:0] r_q;

        always_ff @(posedge Clk or negedge Clrn) begin
            if (!Clrn) begin
                r_q <= '0;
            end else if (w_wr_en && (Wn == AW'(gi))) begin
                r_q <= D;
            end
        end

        assign w_regs[gi] = r_q;
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            r_wcnt <= 8'd0;
        end else if (w_wr_en) begin
            r_wcnt <= r_wcnt + 8'd1;
        end
    end

    always_comb begin
        w_qa = w_regs[Rna];
        w_qb = w_regs[Rnb];
`ifdef REGFILE_WRITE_BYPASS_EN
        // w_wr_en already excludes address 0, so the zero register is never bypassed.
        if (w_wr_en && (Rna == Wn)) begin
            w_qa = D;
        end
        if (w_wr_en && (Rnb == Wn)) begin
            w_qb = D;
        end
`endif
        if (!Clrn) begin
            w_qa = '0;
            w_qb = '0;
        end
    end

    assign Qa   = w_qa;
    assign Qb   = w_qb;
    assign Wcnt = r_wcnt;

endmodule

`default_nettype wire

// File: tb/tb_regfile_32x32.sv
// Scoreboard bench for regfile_32x32: a driver pushes expected read data and
// write count computed from a simple array model; a monitor pops and compares.
`default_nettype none

module tb_regfile_32x32;

    logic        Clk;
    logic        Clrn;
    logic [4:0]  Rna, Rnb, Wn;
    logic [31:0] D;
    logic        We;
    logic [31:0] Qa, Qb;
    logic [7:0]  Wcnt;

    regfile_32x32 #(.DW(32), .AW(5)) dut (
        .Clk(Clk), .Clrn(Clrn), .Rna(Rna), .Rnb(Rnb), .Wn(Wn),
        .D(D), .We(We), .Qa(Qa), .Qb(Qb), .Wcnt(Wcnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic [31:0] qa;
        logic [31:0] qb;
        logic [7:0]  wc;
    } exp_t;

    exp_t  sb_q[$];
    event  chk_ev;
    int    errors = 0;
    int    checks = 0;

    // Reference model: plain array of register contents and a write count.
    logic [31:0] model_mem [0:31];
    int          model_wcnt;

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (!Clrn || a == 5'd0) return 32'd0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (We && Wn != 5'd0 && a == Wn) return D;
`endif
        return model_mem[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model_mem[i] = 32'd0;
        model_wcnt = 0;
    endtask

    // Entered at posedge+1: drive inputs, publish expectation, advance one cycle.
    task automatic step(input string nm, input logic clrn, input logic we,
                        input logic [4:0] wn, input logic [31:0] d,
                        input logic [4:0] ra, input logic [4:0] rb);
        exp_t e;
        Clrn = clrn; We = we; Wn = wn; D = d; Rna = ra; Rnb = rb;
        if (!clrn) model_clear();
        #2;
        e.name = nm;
        e.qa   = model_read(ra);
        e.qb   = model_read(rb);
        e.wc   = 8'(model_wcnt);
        sb_q.push_back(e);
        -> chk_ev;
        @(posedge Clk);
        if (Clrn && We && Wn != 5'd0) begin
            model_mem[Wn] = D;
            model_wcnt = (model_wcnt + 1) % 256;
        end
        #1;
    endtask

    // Monitor: compare every published expectation against the live outputs.
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (Qa !== e.qa) begin
                    errors++;
                    $display("FAIL %s Qa: got %h expected %h", e.name, Qa, e.qa);
                end
                checks++;
                if (Qb !== e.qb) begin
                    errors++;
                    $display("FAIL %s Qb: got %h expected %h", e.name, Qb, e.qb);
                end
                checks++;
                if (Wcnt !== e.wc) begin
                    errors++;
                    $display("FAIL %s Wcnt: got %0d expected %0d", e.name, Wcnt, e.wc);
                end
            end
        end
    end

    initial begin
        logic [31:0] last_d;
        logic [4:0]  ra, rb, wn;
        model_clear();
        Clrn = 1'b0; We = 1'b0; Wn = '0; D = '0; Rna = '0; Rnb = '0;
        @(posedge Clk); #1;

        // Reset state; a write attempted while in reset must be lost.
        step("reset",        1'b0, 1'b1, 5'd3,  32'h12345678, 5'd5,  5'd31);
        step("reset_wlost",  1'b1, 1'b0, 5'd0,  32'h0,        5'd3,  5'd5);
        // First write right after reset release, then read back.
        step("wr21",         1'b1, 1'b1, 5'd21, 32'hDEADBEEF, 5'd0,  5'd21);
        step("rd21",         1'b1, 1'b0, 5'd21, 32'h0,        5'd21, 5'd21);
        // Write to zero register ignored; We=0 leaves state unchanged.
        step("wr0",          1'b1, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd21);
        step("rd0",          1'b1, 1'b0, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd21);
        step("we0",          1'b1, 1'b0, 5'd21, 32'h55555555, 5'd21, 5'd0);
        step("rd21b",        1'b1, 1'b0, 5'd0,  32'h0,        5'd21, 5'd21);
        // Same-cycle read/write hazard on r10.
        step("wr10",         1'b1, 1'b1, 5'd10, 32'h1,        5'd0,  5'd0);
        step("hazard10",     1'b1, 1'b1, 5'd10, 32'h2,        5'd10, 5'd10);
        step("rd10",         1'b1, 1'b0, 5'd0,  32'h0,        5'd10, 5'd21);
        // Async reset mid-cycle with a write pending across the edge.
        step("wr7",          1'b1, 1'b1, 5'd7,  32'hA5A5A5A5, 5'd0,  5'd0);
        step("rd7",          1'b1, 1'b0, 5'd0,  32'h0,        5'd7,  5'd7);
        step("async_rst",    1'b0, 1'b1, 5'd7,  32'h77777777, 5'd7,  5'd21);
        step("post_rst",     1'b1, 1'b0, 5'd0,  32'h0,        5'd7,  5'd21);

        // Randomized traffic, including Wn=0 and Rna==Rnb cases.
        for (int i = 0; i < 300; i++) begin
            wn = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) wn = 5'd0;
            ra = 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) ra = wn;
            step("random", 1'b1, 1'($urandom_range(0, 1)), wn, $urandom, ra, rb);
        end

        // Counter wrap: 256 committed writes to r10 from a clean reset.
        step("wrap_rst", 1'b0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd0);
        last_d = 32'h0;
        for (int i = 0; i < 256; i++) begin
            last_d = $urandom;
            Clrn = 1'b1; We = 1'b1; Wn = 5'd10; D = last_d; Rna = 5'd1; Rnb = 5'd2;
            @(posedge Clk);
            model_mem[10] = last_d;
            model_wcnt = (model_wcnt + 1) % 256;
            #1;
        end
        step("wrap", 1'b1, 1'b0, 5'd0, 32'h0, 5'd10, 5'd10);

        #5;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        checks++;
        if (model_wcnt != 0) begin
            errors++;
            $display("FAIL wrap_model: got %0d expected 0", model_wcnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
